drive_cmd_sequencer: RTL



---
 rtl/drive_cmd_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/drive_cmd_sequencer.sv
// Turns received ASCII drive commands into a one-hot motor direction word,
// forcing an IDLE dead-time before every direction change and stopping on command silence.
module drive_cmd_sequencer #(
   parameter int DEADTIME_CYCLES = 125000,
   parameter int WATCHDOG_CYCLES = 62500000
) (
   input  logic       clk_125mhz,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [4:0] direction,
   output logic       cmd_error,
   output logic       wd_trip,
   output logic       dead_active
);

   localparam logic [4:0] DIR_FWD   = 5'b00001;
   localparam logic [4:0] DIR_IDLE  = 5'b00010;
   localparam logic [4:0] DIR_BACK  = 5'b00100;
   localparam logic [4:0] DIR_LEFT  = 5'b01000;
   localparam logic [4:0] DIR_RIGHT = 5'b10000;

   localparam int DT_W = $clog2(DEADTIME_CYCLES + 1);
   localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

   typedef enum logic [1:0] {IDLE_ST, RUN, DEAD} state_t;

   state_t          state_q, state_d;
   logic [4:0]      target_q, target_d;
   logic [4:0]      dir_q, dir_d;
   logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            cmd_err_q, cmd_err_d;
   logic            wd_trip_q, wd_trip_d;
   logic            dead_q;

   logic [4:0] cmd_dir;
   logic       cmd_motion, cmd_stop, cmd_bad;

   always_comb begin
      cmd_dir    = DIR_IDLE;
      cmd_motion = 1'b0;
      cmd_stop   = 1'b0;
      cmd_bad    = 1'b0;
      if (rx_valid) begin
         case (rx_data)
            8'h46, 8'h66: begin cmd_dir = DIR_FWD;   cmd_motion = 1'b1; end
            8'h42, 8'h62: begin cmd_dir = DIR_BACK;  cmd_motion = 1'b1; end
            8'h4C, 8'h6C: begin cmd_dir = DIR_LEFT;  cmd_motion = 1'b1; end
            8'h52, 8'h72: begin cmd_dir = DIR_RIGHT; cmd_motion = 1'b1; end
            8'h53, 8'h73: cmd_stop = 1'b1;
            default:      cmd_bad  = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      dir_d     = dir_q;
      dt_cnt_d  = dt_cnt_q;
      wd_cnt_d  = (cmd_motion || cmd_stop) ? '0 : wd_cnt_q;
      cmd_err_d = cmd_bad;
      wd_trip_d = 1'b0;
      case (state_q)
         IDLE_ST: begin
            dir_d = DIR_IDLE;
            if (cmd_motion) begin
               state_d  = RUN;
               dir_d    = cmd_dir;
               wd_cnt_d = '0;
            end
         end
         RUN: begin
            if (cmd_motion && (cmd_dir == dir_q)) begin
               wd_cnt_d = '0;
            end else if (cmd_motion || cmd_stop) begin
               state_d  = DEAD;
               target_d = cmd_dir;
               dt_cnt_d = '0;
               dir_d    = DIR_IDLE;
            end else if (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 2)) begin
               // counter would reach WATCHDOG_CYCLES-1 on this edge: stop the car
               state_d   = DEAD;
               target_d  = DIR_IDLE;
               dt_cnt_d  = '0;
               dir_d     = DIR_IDLE;
               wd_trip_d = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
         DEAD: begin
            dir_d = DIR_IDLE;
            if (cmd_motion || cmd_stop) target_d = cmd_dir;
            // a command on the last dead cycle is the one that gets applied
            if (dt_cnt_q == DT_W'(DEADTIME_CYCLES - 1)) begin
               if (target_d != DIR_IDLE) begin
                  state_d  = RUN;
                  dir_d    = target_d;
                  wd_cnt_d = '0;
               end else begin
                  state_d = IDLE_ST;
               end
               target_d = DIR_IDLE;
            end else begin
               dt_cnt_d = dt_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = IDLE_ST;
            dir_d    = DIR_IDLE;
            target_d = DIR_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_125mhz) begin
      if (reset) begin
         state_q   <= IDLE_ST;
         target_q  <= DIR_IDLE;
         dir_q     <= DIR_IDLE;
         dt_cnt_q  <= '0;
         wd_cnt_q  <= '0;
         cmd_err_q <= 1'b0;
         wd_trip_q <= 1'b0;
         dead_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         dir_q     <= dir_d;
         dt_cnt_q  <= dt_cnt_d;
         wd_cnt_q  <= wd_cnt_d;
         cmd_err_q <= cmd_err_d;
         wd_trip_q <= wd_trip_d;
         dead_q    <= (state_d == DEAD);
      end
   end

   assign direction   = dir_q;
   assign cmd_error   = cmd_err_q;
   assign wd_trip     = wd_trip_q;
   assign dead_active = dead_q;

endmodule
